// File: rtl/compare_result_tracker.sv
// compare_result_tracker
//   Consumes equal/greater/lesser results from a 4-bit magnitude comparator
//   over a valid/ready handshake. It keeps saturating per-outcome counts,
//   tracks runs of identical outcomes and raises a blocking alarm when a run
//   reaches STREAK_LEN. The alarm is released with alarm_ack.
//
//   Optional feature: define CMP_TRACK_ERR_EN to reject invalid flag
//   patterns and report them on the sticky err flag. When it is undefined,
//   err is held at 0 and flags are priority-decoded (greater, lesser, equal).
//
// Ports
//   clk, rst_n              clock (rising edge), async active-low reset
//   in_valid / in_ready     result handshake; in_ready is low only in ALARM
//   equal, greater, lesser  comparator flags
//   clear                   synchronous clear; overrides everything else
//   alarm_ack               releases an active alarm
//   eq_count/gt_count/lt_count  saturating outcome counters (CNT_W bits)
//   streak_alarm            run threshold reached
//   alarm_kind              kind that raised the alarm (01 eq, 10 gt, 11 lt)
//   err                     sticky invalid-pattern flag
module compare_result_tracker #(
  parameter int unsigned CNT_W      = 8,
  parameter int unsigned STREAK_LEN = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             equal,
  input  logic             greater,
  input  logic             lesser,
  input  logic             clear,
  input  logic             alarm_ack,
  output logic [CNT_W-1:0] eq_count,
  output logic [CNT_W-1:0] gt_count,
  output logic [CNT_W-1:0] lt_count,
  output logic             streak_alarm,
  output logic [1:0]       alarm_kind,
  output logic             err
);

  localparam int unsigned RUN_W = 4;

  localparam logic [1:0] K_NONE = 2'b00;
  localparam logic [1:0] K_EQ   = 2'b01;
  localparam logic [1:0] K_GT   = 2'b10;
  localparam logic [1:0] K_LT   = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    TRACK = 2'b01,
    ALARM = 2'b10
  } state_t;

  state_t           state;
  logic [1:0]       last_kind;
  logic [RUN_W-1:0] run_cnt;

  logic             accept_c;
  logic             flags_ok_c;
  logic [1:0]       kind_c;
  logic [RUN_W-1:0] run_nxt_c;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

  // Ready depends on state only, so upstream never sees a combinational path
  // from its own valid.
  assign in_ready = (state != ALARM);
  assign accept_c = in_valid && in_ready;

  // Flag decode into a 2-bit kind.
  always_comb begin
    kind_c     = K_NONE;
    flags_ok_c = 1'b1;
`ifdef CMP_TRACK_ERR_EN
    unique case ({equal, greater, lesser})
      3'b100:  kind_c = K_EQ;
      3'b010:  kind_c = K_GT;
      3'b001:  kind_c = K_LT;
      default: flags_ok_c = 1'b0;
    endcase
`else
    if (greater)     kind_c = K_GT;
    else if (lesser) kind_c = K_LT;
    else if (equal)  kind_c = K_EQ;
`endif
  end

  // Run length the accepted sample would produce.
  assign run_nxt_c = (kind_c == last_kind) ? run_cnt + RUN_W'(1) : RUN_W'(1);

  // Tracker state machine with registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      last_kind    <= K_NONE;
      run_cnt      <= '0;
      eq_count     <= '0;
      gt_count     <= '0;
      lt_count     <= '0;
      streak_alarm <= 1'b0;
      alarm_kind   <= K_NONE;
      err          <= 1'b0;
    end else if (clear) begin
      state        <= IDLE;
      last_kind    <= K_NONE;
      run_cnt      <= '0;
      eq_count     <= '0;
      gt_count     <= '0;
      lt_count     <= '0;
      streak_alarm <= 1'b0;
      alarm_kind   <= K_NONE;
      err          <= 1'b0;
    end else begin
      unique case (state)
        IDLE, TRACK: begin
          if (accept_c) begin
            state <= TRACK;
            if (!flags_ok_c) begin
              // Invalid pattern: dropped, breaks the current run.
              err       <= 1'b1;
              last_kind <= K_NONE;
              run_cnt   <= '0;
            end else if (kind_c != K_NONE) begin
              unique case (kind_c)
                K_EQ:    eq_count <= sat_inc(eq_count);
                K_GT:    gt_count <= sat_inc(gt_count);
                default: lt_count <= sat_inc(lt_count);
              endcase
              last_kind <= kind_c;
              run_cnt   <= run_nxt_c;
              if (run_nxt_c == RUN_W'(STREAK_LEN)) begin
                state        <= ALARM;
                streak_alarm <= 1'b1;
                alarm_kind   <= kind_c;
              end
            end
          end
        end
        ALARM: begin
          if (alarm_ack) begin
            state        <= TRACK;
            last_kind    <= K_NONE;
            run_cnt      <= '0;
            streak_alarm <= 1'b0;
            alarm_kind   <= K_NONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_compare_result_tracker.sv
module tb_compare_result_tracker;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic       equal;
  logic       greater;
  logic       lesser;
  logic       clear;
  logic       alarm_ack;
  logic [7:0] eq_count;
  logic [7:0] gt_count;
  logic [7:0] lt_count;
  logic       streak_alarm;
  logic [1:0] alarm_kind;
  logic       err;

  int passed = 0;
  int total  = 0;

  compare_result_tracker #(.CNT_W(8), .STREAK_LEN(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .equal        (equal),
    .greater      (greater),
    .lesser       (lesser),
    .clear        (clear),
    .alarm_ack    (alarm_ack),
    .eq_count     (eq_count),
    .gt_count     (gt_count),
    .lt_count     (lt_count),
    .streak_alarm (streak_alarm),
    .alarm_kind   (alarm_kind),
    .err          (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic flags(input logic e, input logic g, input logic l);
    equal   = e;
    greater = g;
    lesser  = l;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  initial begin
    rst_n = 1'b1; in_valid = 1'b0; clear = 1'b0; alarm_ack = 1'b0;
    flags(1'b0, 1'b0, 1'b0);
    #1 rst_n = 1'b0;
    #2;
    check("rst_eq", 32'(eq_count), 32'd0);
    check("rst_gt", 32'(gt_count), 32'd0);
    check("rst_lt", 32'(lt_count), 32'd0);
    check("rst_alarm", 32'(streak_alarm), 32'd0);
    check("rst_kind", 32'(alarm_kind), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_ready", 32'(in_ready), 32'd1);
    tick(); tick();
    @(negedge clk) rst_n = 1'b1;

    // Mixed: 3 greater then 1 equal back to back.
    in_valid = 1'b1;
    flags(1'b0, 1'b1, 1'b0);
    tick(); tick(); tick();
    check("mix_ready", 32'(in_ready), 32'd1);
    flags(1'b1, 1'b0, 1'b0);
    tick();
    in_valid = 1'b0;
    check("mix_gt", 32'(gt_count), 32'd3);
    check("mix_eq", 32'(eq_count), 32'd1);
    check("mix_alarm", 32'(streak_alarm), 32'd0);
    check("mix_ready2", 32'(in_ready), 32'd1);

    // Alarm handshake: 4 lesser, then equal held during ALARM.
    do_clear();
    check("clr_gt", 32'(gt_count), 32'd0);
    check("clr_eq", 32'(eq_count), 32'd0);
    in_valid = 1'b1;
    flags(1'b0, 1'b0, 1'b1);
    tick(); tick(); tick();
    check("al_pre", 32'(streak_alarm), 32'd0);
    tick();
    flags(1'b1, 1'b0, 1'b0);
    check("al_alarm", 32'(streak_alarm), 32'd1);
    check("al_kind", 32'(alarm_kind), 32'd3);
    check("al_ready", 32'(in_ready), 32'd0);
    check("al_lt", 32'(lt_count), 32'd4);
    tick(); tick();
    check("al_hold_eq", 32'(eq_count), 32'd0);
    check("al_hold_alarm", 32'(streak_alarm), 32'd1);
    alarm_ack = 1'b1;
    tick();
    alarm_ack = 1'b0;
    check("ack_ready", 32'(in_ready), 32'd1);
    check("ack_alarm", 32'(streak_alarm), 32'd0);
    check("ack_kind", 32'(alarm_kind), 32'd0);
    check("ack_eq0", 32'(eq_count), 32'd0);
    tick();
    in_valid = 1'b0;
    check("ack_eq1", 32'(eq_count), 32'd1);
    alarm_ack = 1'b1;
    tick();
    alarm_ack = 1'b0;
    check("ack_ignored", 32'(in_ready), 32'd1);

    // Saturation: 600 alternating greater/lesser.
    do_clear();
    in_valid = 1'b1;
    for (int i = 0; i < 600; i++) begin
      if (i % 2 == 0) flags(1'b0, 1'b1, 1'b0);
      else            flags(1'b0, 1'b0, 1'b1);
      tick();
    end
    in_valid = 1'b0;
    check("sat_gt", 32'(gt_count), 32'd255);
    check("sat_lt", 32'(lt_count), 32'd255);
    check("sat_eq", 32'(eq_count), 32'd0);
    check("sat_alarm", 32'(streak_alarm), 32'd0);
    check("sat_ready", 32'(in_ready), 32'd1);

    // Clear collides with an accepted greater and alarm_ack.
    in_valid = 1'b1; flags(1'b0, 1'b1, 1'b0);
    alarm_ack = 1'b1; clear = 1'b1;
    tick();
    clear = 1'b0; alarm_ack = 1'b0; in_valid = 1'b0;
    check("cc_gt", 32'(gt_count), 32'd0);
    check("cc_lt", 32'(lt_count), 32'd0);
    check("cc_ready", 32'(in_ready), 32'd1);
    // Same collision while in ALARM.
    in_valid = 1'b1;
    tick(); tick(); tick(); tick();
    check("cc_al_alarm", 32'(streak_alarm), 32'd1);
    check("cc_al_kind", 32'(alarm_kind), 32'd2);
    alarm_ack = 1'b1; clear = 1'b1;
    tick();
    clear = 1'b0; alarm_ack = 1'b0; in_valid = 1'b0;
    check("cc2_gt", 32'(gt_count), 32'd0);
    check("cc2_alarm", 32'(streak_alarm), 32'd0);
    check("cc2_kind", 32'(alarm_kind), 32'd0);
    check("cc2_ready", 32'(in_ready), 32'd1);

`ifdef CMP_TRACK_ERR_EN
    // Invalid pattern breaks the run and sets err.
    in_valid = 1'b1;
    flags(1'b0, 1'b1, 1'b0); tick(); tick();
    flags(1'b0, 1'b1, 1'b1); tick();
    flags(1'b0, 1'b1, 1'b0); tick();
    check("err_flag", 32'(err), 32'd1);
    check("err_gt", 32'(gt_count), 32'd3);
    check("err_lt", 32'(lt_count), 32'd0);
    tick(); tick();
    check("err_noalarm", 32'(streak_alarm), 32'd0);
    tick();
    in_valid = 1'b0;
    check("err_alarm", 32'(streak_alarm), 32'd1);
    check("err_gt6", 32'(gt_count), 32'd6);
    do_clear();
    check("err_clr", 32'(err), 32'd0);
    in_valid = 1'b1;
    flags(1'b0, 1'b0, 1'b0); tick();
    in_valid = 1'b0;
    check("err_zero", 32'(err), 32'd1);
    check("err_zero_cnt", 32'(gt_count + eq_count + lt_count), 32'd0);
    do_clear();
`else
    // Multi-flag priority decode and dropped all-zero samples.
    in_valid = 1'b1;
    flags(1'b0, 1'b1, 1'b0); tick(); tick();
    flags(1'b0, 1'b1, 1'b1); tick();
    flags(1'b0, 1'b1, 1'b0); tick();
    in_valid = 1'b0;
    check("pri_gt", 32'(gt_count), 32'd4);
    check("pri_lt", 32'(lt_count), 32'd0);
    check("pri_alarm", 32'(streak_alarm), 32'd1);
    check("pri_kind", 32'(alarm_kind), 32'd2);
    check("pri_err", 32'(err), 32'd0);
    alarm_ack = 1'b1; tick(); alarm_ack = 1'b0;
    in_valid = 1'b1;
    flags(1'b0, 1'b1, 1'b0); tick(); tick();
    flags(1'b0, 1'b0, 1'b0); tick();
    flags(1'b0, 1'b1, 1'b0); tick();
    check("zero_gt", 32'(gt_count), 32'd7);
    check("zero_noalarm", 32'(streak_alarm), 32'd0);
    tick();
    check("zero_alarm", 32'(streak_alarm), 32'd1);
    in_valid = 1'b0;
    alarm_ack = 1'b1; tick(); alarm_ack = 1'b0;
    in_valid = 1'b1;
    flags(1'b1, 1'b0, 1'b1); tick();
    in_valid = 1'b0;
    check("pri_el_lt", 32'(lt_count), 32'd1);
    check("pri_el_eq", 32'(eq_count), 32'd0);
    do_clear();
`endif

    // Reset while in ALARM with gt_count = 5.
    in_valid = 1'b1;
    flags(1'b0, 1'b1, 1'b0); tick();
    flags(1'b0, 1'b0, 1'b1); tick();
    flags(1'b0, 1'b1, 1'b0); tick(); tick(); tick(); tick();
    in_valid = 1'b0;
    check("pre_rst_gt", 32'(gt_count), 32'd5);
    check("pre_rst_alarm", 32'(streak_alarm), 32'd1);
    check("pre_rst_ready", 32'(in_ready), 32'd0);
    rst_n = 1'b0;
    #2;
    check("mid_rst_gt", 32'(gt_count), 32'd0);
    check("mid_rst_lt", 32'(lt_count), 32'd0);
    check("mid_rst_alarm", 32'(streak_alarm), 32'd0);
    check("mid_rst_ready", 32'(in_ready), 32'd1);
    @(negedge clk) rst_n = 1'b1;
    tick();
    check("post_rst_ready", 32'(in_ready), 32'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/compare_result_tracker.md
# compare_result_tracker

Downstream consumer of the 4-bit magnitude comparator's `equal`/`greater`/`lesser` flags. It accepts one result per valid/ready handshake and keeps saturating per-outcome counts. It tracks runs of identical outcomes and raises a blocking alarm when a run reaches a programmed length. Software or a supervisor block reads the counts and acknowledges alarms.

## Interface
Parameters:
- `CNT_W`, 8: width of each outcome counter.
- `STREAK_LEN`, 4: run length that triggers an alarm, 2..15.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `in_valid`  in  1  comparator result present.
- `in_ready`  out  1  tracker can accept a result.
- `equal`  in  1  comparator equal flag.
- `greater`  in  1  comparator greater flag.
- `lesser`  in  1  comparator lesser flag.
- `clear`  in  1  synchronous clear of counts, run tracking, alarm and error.
- `alarm_ack`  in  1  one-cycle pulse that releases an alarm.
- `eq_count`  out  CNT_W  number of equal results accepted.
- `gt_count`  out  CNT_W  number of greater results accepted.
- `lt_count`  out  CNT_W  number of lesser results accepted.
- `streak_alarm`  out  1  run threshold reached.
- `alarm_kind`  out  2  outcome kind that caused the alarm.
- `err`  out  1  sticky flag for an invalid flag pattern.

## Operation
- A sample is accepted when `in_valid && in_ready` is true at the clock edge.
- `in_ready` is high whenever the state is not ALARM. It is combinational from state only.
- Kind encoding: 00 = none, 01 = equal, 10 = greater, 11 = lesser.
- Valid pattern: exactly one of `equal`, `greater`, `lesser` is set.
- Counting: on acceptance of a valid sample, the matching counter increments. Counters saturate at 2^CNT_W-1 and never wrap.
- Run tracking: an internal last-kind register (2 bits) and a run counter (4 bits).
  - Same kind as last: run counter increments.
  - Different kind: last-kind is set to the new kind and the run counter is set to 1.
- States:
  - IDLE: the state after reset or `clear`. The first accepted sample moves the block to TRACK.
  - TRACK: when an accepted sample makes the run counter equal STREAK_LEN, the block moves to ALARM. `streak_alarm` goes to 1 and `alarm_kind` is set to that kind.
  - ALARM: `in_ready` = 0. On `alarm_ack` the block returns to TRACK, the run counter goes to 0, last-kind goes to 00, `streak_alarm` goes to 0, and `alarm_kind` goes to 00.
- Priority: `clear` overrides everything in the same cycle, including acceptance and `alarm_ack`. After `clear`, all counts are 0, the run counter and last-kind are cleared, `err` = 0, and the state is IDLE.
- `alarm_ack` outside ALARM is ignored.

## Timing
- All outputs are registered. Counts, `streak_alarm` and `alarm_kind` reflect an accepted sample on the cycle after the accepting edge.
- `in_ready` falls in the cycle after the sample that triggers the alarm. Release takes effect the cycle after `alarm_ack`.
- Throughput in TRACK/IDLE is one sample per clock.
- Reset values are driven immediately on `rst_n` low, independent of `clk`:
  - all counts = 0
  - `streak_alarm` = 0, `alarm_kind` = 00, `err` = 0
  - state = IDLE, so `in_ready` = 1
- Reset mid-ALARM abandons the alarm with no acknowledge required.
- A pending `in_valid` during ALARM is not consumed. The upstream stage holds its data.

## Configuration
- `CMP_TRACK_ERR_EN` defined:
  - An accepted invalid pattern (zero flags or more than one flag) is dropped: no counter changes.
  - `err` is set and stays set until reset or `clear`.
  - The run counter and last-kind are cleared.
  - State is otherwise unchanged; IDLE still moves to TRACK.
- `CMP_TRACK_ERR_EN` undefined:
  - `err` is tied to 0.
  - Multi-flag patterns are priority-decoded as greater, then lesser, then equal.
  - An all-zero pattern is accepted and dropped with no effect on counts or run tracking.

## Test plan
All scenarios use CNT_W=8, STREAK_LEN=4.
- Reset: drive `rst_n` low while in ALARM with `gt_count`=5 -> `gt_count`=0, `streak_alarm`=0, `in_ready`=1 before the next edge.
- Mixed: 3 greater then 1 equal, back to back -> `gt_count`=3, `eq_count`=1, `streak_alarm` stays 0, `in_ready` stays 1.
- Alarm handshake:
  - Stimulus: 4 consecutive lesser, then hold `in_valid`=1 with equal.
  - Response: `streak_alarm`=1 and `alarm_kind`=11 the cycle after the 4th sample; `in_ready`=0; `eq_count` stays 0.
  - Pulse `alarm_ack`: `in_ready`=1 the next cycle and the held equal is accepted (`eq_count`=1).
- Saturation: 600 samples alternating greater/lesser -> `gt_count`=`lt_count`=255, no wrap, no alarm.
- Clear collision: `clear`=1 in the same cycle as an accepted greater and `alarm_ack` -> all counts 0, state IDLE, `gt_count` stays 0.
- Error (with `CMP_TRACK_ERR_EN`):
  - Stimulus: greater, greater, then the pattern `greater`=`lesser`=1, then greater.
  - Response: `err`=1 and `gt_count`=3; the run restarts at 1, so no alarm until 3 further greater samples.
